// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter states, defaults and bit-count clamp.
// PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned MIN_BITS       = 5;
    localparam int unsigned MAX_BITS       = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_e;

    // Out-of-range counts (0..4, 9..15) fall back to a full byte.
    function automatic logic [3:0] eff_bits(input logic [3:0] n);
        if (n >= 4'(MIN_BITS) && n <= 4'(MAX_BITS))
            return n;
        return 4'(MAX_BITS);
    endfunction

endpackage

// File: rtl/uart_rs232_tx_if.sv
// uart_rs232_tx_if: character request/done handshake, tick and serial line.
// master = upstream sequencer side, slave = transmitter side.
interface uart_rs232_tx_if;
    logic       tick;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [3:0] n_bits;
    logic       tx;
    logic       tx_done;

    modport master (
        output tick, tx_en, tx_data, n_bits,
        input  tx, tx_done
    );

    modport slave (
        input  tick, tx_en, tx_data, n_bits,
        output tx, tx_done
    );
endinterface

// File: rtl/uart_rs232_tx.sv
// uart_rs232_tx: RS-232 frame transmitter (start, 5..8 data LSB-first, stop).
// Define UART_TX_PARITY_EN to insert a parity bit before the stop bit.
module uart_rs232_tx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter bit          PARITY_ODD = 1'b0
) (
    input logic            clk,
    input logic            reset,
    uart_rs232_tx_if.slave bus
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    last_bit_q, last_bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          timed;
    logic          bit_end;
    logic [3:0]    eff_n;

    assign eff_n   = eff_bits(bus.n_bits);
    assign timed   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bit_end = timed && bus.tick && (tick_cnt_q == TICK_LAST);

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
    logic [7:0] data_mask;

    assign data_mask = 8'hFF >> (4'd8 - eff_n);
`else
    logic unused_parity_cfg;

    assign unused_parity_cfg = PARITY_ODD;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.tx_en) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:
                if (bit_end && bit_cnt_q == last_bit_q)
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
            S_PARITY: if (bit_end) state_d = S_STOP;
`else
                    state_d = S_STOP;
`endif
            S_STOP:  if (bit_end) state_d = S_DONE;
            S_DONE:  if (!bus.tx_en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        if (state_q == S_IDLE) begin
            if (bus.tx_en) begin
                shift_d    = bus.tx_data;
                last_bit_d = 3'(eff_n - 4'd1);
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
                par_d      = ^(bus.tx_data & data_mask) ^ PARITY_ODD;
`endif
            end
        end else if (timed && bus.tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
            if (bit_end && state_q == S_DATA) begin
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // tx follows the current state; tx_done follows the next state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_q;
`endif
            default:  tx_d = 1'b1;
        endcase
        done_d = (state_d == S_DONE);
    end

    assign bus.tx      = tx_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_rs232_tx.sv
// tb_uart_rs232_tx: vector table, hand sequences and random frames
// checked against a bit-list frame model.
module tb_uart_rs232_tx;

    localparam int OS = 16;
    localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   exp_q[$];

    uart_rs232_tx_if bif ();

    uart_rs232_tx #(
        .OVERSAMPLE (OS),
        .PARITY_ODD (PODD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] nb;
        int         done_tick;
        int         hold;
        string      name;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected line levels, one entry per serial bit.
    task automatic build_model(input logic [7:0] d, input logic [3:0] nb);
        int n;
        bit par;
        n = (nb >= 5 && nb <= 8) ? int'(nb) : 8;
        par = PODD;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            par ^= d[i];
        end
        if (P == 1) exp_q.push_back(par);
        exp_q.push_back(1'b1);
    endtask

    // Two quiet clocks then a one-clock tick.
    task automatic tick_slot();
        bif.tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bif.tick = 1'b1;
    endtask

    // Called at a negedge while the DUT is idle.
    task automatic run_frame(input logic [7:0] d, input logic [3:0] nb,
                             input int done_tick, input int hold,
                             input string nm);
        int t;
        int bad;
        build_model(d, nb);
        bif.tx_en   = 1'b1;
        bif.tx_data = d;
        bif.n_bits  = nb;
        bif.tick    = 1'b0;
        @(negedge clk);
        chk({nm, " tx_lag"}, int'(bif.tx), 1);
        bif.tx_data = 8'($urandom);
        bif.n_bits  = 4'($urandom);
        @(negedge clk);
        chk({nm, " start"}, int'(bif.tx), 0);
        t = 0;
        while (t < done_tick) begin
            tick_slot();
            t++;
            if (t == done_tick)
                chk({nm, " done_early"}, int'(bif.tx_done), 0);
            @(negedge clk);
            bif.tick = 1'b0;
            if (t % OS == OS / 2 && t / OS < exp_q.size())
                chk($sformatf("%s bit%0d", nm, t / OS),
                    int'(bif.tx), int'(exp_q[t / OS]));
        end
        chk({nm, " done"}, int'(bif.tx_done), 1);
        bad = 0;
        for (int k = 0; k < hold; k++) begin
            tick_slot();
            @(negedge clk);
            bif.tick = 1'b0;
            if (bif.tx !== 1'b1 || bif.tx_done !== 1'b1) bad++;
        end
        chk({nm, " hold"}, bad, 0);
        bif.tx_en = 1'b0;
        @(negedge clk);
        chk({nm, " done_clr"}, int'(bif.tx_done), 0);
        chk({nm, " idle_tx"}, int'(bif.tx), 1);
    endtask

    initial begin
        int bad;
        int n;
        logic [7:0] rd;
        logic [3:0] rn;

        vecs[0] = '{8'h55, 4'd8,  (10 + P) * OS, 4,          "x55_n8"};
        vecs[1] = '{8'hFF, 4'd5,  (7 + P) * OS,  4,          "xFF_n5"};
        vecs[2] = '{8'hE0, 4'd5,  (7 + P) * OS,  4,          "xE0_n5"};
        vecs[3] = '{8'hA3, 4'd0,  (10 + P) * OS, 4,          "xA3_n0"};
        vecs[4] = '{8'hA3, 4'd12, (10 + P) * OS, 3 * 10 * OS, "xA3_n12"};
        vecs[5] = '{8'h07, 4'd8,  (10 + P) * OS, 4,          "x07_n8"};

        reset       = 1'b1;
        bif.tick    = 1'b0;
        bif.tx_en   = 1'b1;
        bif.tx_data = 8'h00;
        bif.n_bits  = 4'd8;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            bif.tick = (i % 3 == 2);
            @(negedge clk);
            chk("rst_tx", int'(bif.tx), 1);
            chk("rst_done", int'(bif.tx_done), 0);
        end
        reset     = 1'b0;
        bif.tx_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            bif.tick = (i % 3 == 2);
            @(negedge clk);
            if (bif.tx !== 1'b1 || bif.tx_done !== 1'b0) bad++;
        end
        bif.tick = 1'b0;
        chk("post_rst_idle", bad, 0);

        for (int v = 0; v < 6; v++)
            run_frame(vecs[v].data, vecs[v].nb, vecs[v].done_tick,
                      vecs[v].hold, vecs[v].name);

        // Re-request one clock after release: run_frame raises tx_en now.
        run_frame(8'h3C, 4'd7, (9 + P) * OS, 2, "b2b");

        // Abort a frame mid data.
        bif.tx_en   = 1'b1;
        bif.tx_data = 8'h00;
        bif.n_bits  = 4'd8;
        for (int i = 0; i < 40; i++) begin
            tick_slot();
            @(negedge clk);
            bif.tick = 1'b0;
        end
        chk("abort_pre_tx", int'(bif.tx), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_tx", int'(bif.tx), 1);
        chk("abort_done", int'(bif.tx_done), 0);
        reset     = 1'b0;
        bif.tx_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            bif.tick = (i % 3 == 2);
            @(negedge clk);
            if (bif.tx !== 1'b1) bad++;
        end
        bif.tick = 1'b0;
        chk("abort_idle", bad, 0);

        for (int r = 0; r < 8; r++) begin
            rd = 8'($urandom);
            rn = 4'($urandom_range(0, 15));
            n  = (rn >= 5 && rn <= 8) ? int'(rn) : 8;
            run_frame(rd, rn, (2 + n + P) * OS, 3,
                      $sformatf("rnd%0d_%02h_n%0d", r, rd, rn));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rs232_tx.md
# uart_rs232_tx

Serial transmitter for the board's RS-232 debug link. It turns one parallel byte into an asynchronous frame: start bit, 5–8 data bits LSB-first, optional parity bit, one stop bit. Bit timing is set by an external oversampling tick from the shared baud-rate generator. Upstream message sequencers drive it with a level request and a level done handshake, one character at a time.

## Interface
- OVERSAMPLE, default 16: number of `tick` pulses per serial bit.
- PARITY_ODD, default 0: parity sense when parity is compiled in (0 = even, 1 = odd).
- clk  in  1: system clock; all logic on its rising edge.
- reset  in  1: reset, synchronous, active-high; clock clk.
- tick  in  1: one-clk-wide enable pulse at OVERSAMPLE × baud rate.
- tx_en  in  1: level transmit request.
- tx_data  in  8: character to send; bits above n_bits are ignored.
- n_bits  in  4: data-bit count; valid range 5..8.
- tx  out  1: serial line; idle high.
- tx_done  out  1: level; high from end of stop bit until tx_en is released.

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP, DONE.
- IDLE: tx=1, tx_done=0. If tx_en=1, latch tx_data into the shift register, latch the effective bit count, clear the tick and bit counters, and go to START.
- Effective bit count: n_bits when 5..8. Any other value, including 0 and 9..15, is treated as 8.
- START: tx=0. After OVERSAMPLE ticks, go to DATA.
- DATA: tx = shift_reg[0]. Every OVERSAMPLE ticks, shift right and increment the bit counter. After the last bit, go to PARITY if compiled in, else STOP.
- PARITY: tx = XOR of the sent data bits, XOR PARITY_ODD. Lasts OVERSAMPLE ticks, then go to STOP.
- STOP: tx=1 for OVERSAMPLE ticks, then go to DONE.
- DONE: tx=1, tx_done=1. Stay until tx_en=0, then go to IDLE with tx_done=0 on the same edge.
- A new frame needs tx_en low for at least one clk after tx_done. Holding tx_en high never produces back-to-back frames.
- tx_data and n_bits changes after the latch cycle have no effect on the current frame.
- Ticks arriving in IDLE or DONE are ignored.

## Timing
- Reset values: tx=1, tx_done=0, state IDLE, all counters 0.
- Reset mid-frame aborts the frame; tx=1 on the next edge.
- tx and tx_done are registered outputs. tx falls on the edge after the edge that samples tx_en=1 in IDLE.
- Each bit lasts exactly OVERSAMPLE ticks. The start bit additionally includes the sub-tick gap between the request and the first tick.
- Frame length in ticks is (2 + N + P) × OVERSAMPLE, where N is the effective bit count and P is 1 with parity, 0 without.
- tx_done rises on the clk edge that counts the last stop-bit tick.
- If tick and a state exit coincide in one cycle, that tick is counted in the old state.
- Tick counter width is clog2(OVERSAMPLE). The bit counter is 3 bits and compares against N−1.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state exists and one parity bit is inserted between data and stop.
- UART_TX_PARITY_EN undefined: no parity logic, PARITY_ODD is unused, and the frame is start + data + stop.

## Structure
- Shared package uart_pkg holds:
  - the state enum;
  - the default OVERSAMPLE constant;
  - MIN_BITS=5 and MAX_BITS=8, used for the bit-count clamp.
- Single flat module with no sub-module. The tick generator stays external and is shared with the receiver.

## Test plan
- Reset held during tx_en=1 → tx=1 and tx_done=0 throughout; no frame after release until tx_en re-pulses.
- tx_data=0x55, n_bits=8, no parity → tx = 0,1,0,1,0,1,0,1,0 then stop 1, each bit 16 ticks. tx_done rises at tick 160 and clears one clk after tx_en drops.
- tx_data=0xFF, n_bits=5 → start, five 1s, stop; tx_done at tick 112. tx_data[7:5] never appears on tx.
- n_bits=0 and n_bits=12 with tx_data=0xA3 → both identical to n_bits=8: frame 0, 1,1,0,0,0,1,0,1, 1.
- tx_en held high for 3 frame times → exactly one frame. tx_en low one clk then high → second frame starts on the next edge.
- With UART_TX_PARITY_EN, tx_data=0x07, n_bits=8, PARITY_ODD=0 → parity bit 1. Frame is 176 ticks; tx_done at tick 176.
